// File: rtl/avr_io_timer.sv
// 8-bit timer/counter on the CPU I/O bus: TCNT/OCR/TCCR/TIFR at BASE_ADDR..+3.
// Ports: clk, rst, io_addr/io_read/io_write/io_din/io_dout, irq_ovf, irq_cmp, oc.
module avr_io_timer #(
  parameter logic [5:0] BASE_ADDR = 6'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] io_addr,
  input  logic       io_read,
  input  logic       io_write,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       irq_ovf,
  output logic       irq_cmp,
  output logic       oc
);

  logic [7:0] tcnt;
  logic [7:0] ocr;
  logic [6:0] tccr;
  logic       tov;
  logic       ocf;
  logic [9:0] presc;

  logic [5:0] off;
  logic       in_rng;
  logic       wr_tcnt;
  logic       wr_ocr;
  logic       wr_tccr;
  logic       wr_tifr;

  assign off     = io_addr - BASE_ADDR;
  assign in_rng  = (off < 6'd4);
  assign wr_tcnt = io_write && in_rng && (off[1:0] == 2'd0);
  assign wr_ocr  = io_write && in_rng && (off[1:0] == 2'd1);
  assign wr_tccr = io_write && in_rng && (off[1:0] == 2'd2);
  assign wr_tifr = io_write && in_rng && (off[1:0] == 2'd3);

  logic [2:0] cs;
  logic       ctc;
  logic       ocen;

  assign cs   = tccr[2:0];
  assign ctc  = tccr[3];
  assign ocen = tccr[4];

  logic [9:0] lim;
  logic       run;

  always_comb begin
    lim = 10'd0;
    run = 1'b1;
    unique case (cs)
      3'd1:    lim = 10'd0;
      3'd2:    lim = 10'd7;
      3'd3:    lim = 10'd63;
      3'd4:    lim = 10'd255;
      3'd5:    lim = 10'd1023;
      default: run = 1'b0;
    endcase
  end

  logic tick;
  logic match;
  logic ev;
  logic set_ocf;
  logic set_tov;

  assign tick  = run && (presc == lim);
  assign match = (tcnt == ocr);
  // A CPU write to TCNT pre-empts the counting event entirely.
  assign ev      = tick && !wr_tcnt;
  assign set_ocf = ev && match;
  assign set_tov = ev && (tcnt == 8'hFF) && !(ctc && match);

  logic [7:0] tcnt_nx;

  always_comb begin
    tcnt_nx = tcnt;
    if (wr_tcnt)
      tcnt_nx = io_din;
    else if (ev) begin
      if ((ctc && match) || tcnt == 8'hFF)
        tcnt_nx = 8'h00;
      else
        tcnt_nx = tcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= 8'h00;
      ocr   <= 8'h00;
      tccr  <= 7'h00;
      tov   <= 1'b0;
      ocf   <= 1'b0;
      presc <= 10'd0;
      oc    <= 1'b0;
    end else begin
      tcnt <= tcnt_nx;
      if (wr_ocr)
        ocr <= io_din;
      if (wr_tccr)
        tccr <= io_din[6:0];
      if (wr_tccr)
        presc <= 10'd0;
      else if (run)
        presc <= tick ? 10'd0 : presc + 10'd1;
      // Setting a flag wins over a write-1-to-clear in the same cycle.
      tov <= set_tov | (tov & ~(wr_tifr & io_din[0]));
      ocf <= set_ocf | (ocf & ~(wr_tifr & io_din[1]));
      if (set_ocf && ocen)
        oc <= ~oc;
    end
  end

  assign irq_ovf = tov & tccr[5];
  assign irq_cmp = ocf & tccr[6];

  always_comb begin
    io_dout = 8'h00;
    if (io_read && in_rng) begin
      unique case (1'b1)
        off[1:0] == 2'd0: io_dout = tcnt;
        off[1:0] == 2'd1: io_dout = ocr;
        off[1:0] == 2'd2: io_dout = {1'b0, tccr};
        off[1:0] == 2'd3: io_dout = {6'b0, ocf, tov};
        default:          io_dout = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_io_timer.sv
// Randomized + directed bench for avr_io_timer against a behavioural model.
// Ports exercised: full I/O bus, irq_ovf, irq_cmp, oc.
module tb_avr_io_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] io_addr = 6'h00;
  logic       io_read = 1'b0;
  logic       io_write = 1'b0;
  logic [7:0] io_din = 8'h00;
  logic [7:0] io_dout;
  logic       irq_ovf;
  logic       irq_cmp;
  logic       oc;

  avr_io_timer #(.BASE_ADDR(6'h30)) dut (
    .clk(clk), .rst(rst),
    .io_addr(io_addr), .io_read(io_read),
    .io_write(io_write), .io_din(io_din),
    .io_dout(io_dout), .irq_ovf(irq_ovf),
    .irq_cmp(irq_cmp), .oc(oc)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // behavioural model state
  logic [7:0] m_tcnt, m_ocr, m_tccr;
  bit         m_tov, m_ocf, m_oc;
  int         m_runcyc;  // running cycles since last TCCR write

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_tcnt = 0; m_ocr = 0; m_tccr = 0;
    m_tov = 0; m_ocf = 0; m_oc = 0; m_runcyc = 0;
  endtask

  function automatic int divisor(input logic [2:0] cs);
    case (cs)
      3'd1: return 1;
      3'd2: return 8;
      3'd3: return 64;
      3'd4: return 256;
      3'd5: return 1024;
      default: return 0;
    endcase
  endfunction

  // Advance the model across one rising edge with the given bus write.
  task automatic m_edge(input bit wr, input logic [5:0] a,
                        input logic [7:0] d);
    int  div, off;
    bit  tick, sel, hit, set_o, set_t;
    logic [7:0] nt;
    div = divisor(m_tccr[2:0]);
    tick = 0;
    if (div != 0) begin
      tick = ((m_runcyc + 1) % div) == 0;
      m_runcyc++;
    end
    off = int'(a) - 'h30;
    sel = wr && off >= 0 && off < 4;
    set_o = 0; set_t = 0;
    nt = m_tcnt;
    if (tick && !(sel && off == 0)) begin
      hit = (m_tcnt == m_ocr);
      set_o = hit;
      if (m_tccr[3] && hit) nt = 0;
      else if (m_tcnt == 8'hFF) begin nt = 0; set_t = 1; end
      else nt = m_tcnt + 1;
      if (hit && m_tccr[4]) m_oc = !m_oc;
    end
    m_tcnt = (sel && off == 0) ? d : nt;
    if (sel && off == 1) m_ocr = d;
    if (sel && off == 2) begin m_tccr = d & 8'h7F; m_runcyc = 0; end
    m_tov = set_t || (m_tov && !(sel && off == 3 && d[0]));
    m_ocf = set_o || (m_ocf && !(sel && off == 3 && d[1]));
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] v);
    io_addr = a; io_read = 1'b1;
    #1 v = io_dout;
    io_read = 1'b0;
  endtask

  task automatic check_all();
    logic [7:0] v;
    rd(6'h30, v); chk("tcnt", v, m_tcnt);
    rd(6'h31, v); chk("ocr", v, m_ocr);
    rd(6'h32, v); chk("tccr", v, m_tccr);
    rd(6'h33, v); chk("tifr", v, {6'b0, m_ocf, m_tov});
    #1 chk("idle_dout", io_dout, 8'h00);
    chk("irq_ovf", {7'b0, irq_ovf}, {7'b0, m_tov && m_tccr[5]});
    chk("irq_cmp", {7'b0, irq_cmp}, {7'b0, m_ocf && m_tccr[6]});
    chk("oc", {7'b0, oc}, {7'b0, m_oc});
  endtask

  task automatic step(input bit wr, input logic [5:0] a,
                      input logic [7:0] d);
    io_write = wr; io_addr = a; io_din = d;
    m_edge(wr, a, d);
    @(posedge clk);
    #1 io_write = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'h00, 8'h00);
  endtask

  logic [7:0] v;
  logic [5:0] ra;
  logic [7:0] rdat;
  int         guard;

  initial begin
    m_reset();
    rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check_all();

    // reset mid-count
    step(1'b1, 6'h31, 8'h80);
    step(1'b1, 6'h32, 8'h71);
    idle(5);
    #2 rst = 1'b1;
    m_reset();
    #1 check_all();
    rd(6'h30, v); chk("rst_tcnt", v, 8'h00);
    rst = 1'b0;
    idle(3);
    rd(6'h30, v); chk("rst_hold", v, 8'h00);

    // overflow wrap with CS=1
    step(1'b1, 6'h30, 8'hFD);
    step(1'b1, 6'h32, 8'h21);
    rd(6'h30, v); chk("wrap_fd", v, 8'hFD);
    step(1'b0, 6'h00, 8'h00);
    rd(6'h30, v); chk("wrap_fe", v, 8'hFE);
    step(1'b0, 6'h00, 8'h00);
    rd(6'h30, v); chk("wrap_ff", v, 8'hFF);
    step(1'b0, 6'h00, 8'h00);
    rd(6'h30, v); chk("wrap_00", v, 8'h00);
    chk("wrap_irq", {7'b0, irq_ovf}, 8'h01);

    // CS=2: first increment 8 cycles after the TCCR write
    step(1'b1, 6'h32, 8'h00);
    step(1'b1, 6'h33, 8'h03);
    step(1'b1, 6'h30, 8'h00);
    step(1'b1, 6'h32, 8'h02);
    for (int i = 1; i < 8; i++) step(1'b0, 6'h00, 8'h00);
    rd(6'h30, v); chk("div8_pre", v, 8'h00);
    step(1'b0, 6'h00, 8'h00);
    rd(6'h30, v); chk("div8_first", v, 8'h01);
    idle(8);
    rd(6'h30, v); chk("div8_second", v, 8'h02);

    // CTC with OCR=4, oc toggling
    step(1'b1, 6'h32, 8'h00);
    step(1'b1, 6'h30, 8'h00);
    step(1'b1, 6'h31, 8'h04);
    step(1'b1, 6'h32, 8'h59);
    idle(5);
    chk("ctc_oc1", {7'b0, oc}, 8'h01);
    rd(6'h30, v); chk("ctc_zero", v, 8'h00);
    idle(5);
    chk("ctc_oc2", {7'b0, oc}, 8'h00);
    idle(7);
    rd(6'h33, v); chk("ctc_notov", v & 8'h01, 8'h00);

    // write-1-clear racing a new match: OCF stays set
    guard = 0;
    while (m_tcnt != m_ocr && guard < 20) begin
      step(1'b0, 6'h00, 8'h00);
      guard++;
    end
    chk("match_found", m_tcnt, m_ocr);
    step(1'b1, 6'h33, 8'h03);
    rd(6'h33, v); chk("ocf_wins", v, 8'h02);
    step(1'b1, 6'h33, 8'h03);
    rd(6'h33, v); chk("tifr_clr", v, 8'h00);

    // TCNT write coincident with a tick, unselected read
    step(1'b1, 6'h30, 8'h10);
    rd(6'h30, v); chk("tcnt_wr_tick", v, 8'h10);
    rd(6'h20, v); chk("unsel_rd", v, 8'h00);
    rd(6'h34, v); chk("unsel_hi", v, 8'h00);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        step(1'b0, 6'h00, 8'h00);
      end else begin
        ra = 6'h2E + 6'($urandom_range(0, 7));
        rdat = 8'($urandom);
        if (ra == 6'h32 && $urandom_range(0, 2) != 0)
          rdat[2:0] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2;
        if (ra == 6'h31) rdat = 8'($urandom_range(0, 12));
        step(1'b1, ra, rdat);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
